// File: rtl/simon_game_ctrl_pkg.sv
// Shared definitions for the Simon game controller: state codes, colour codes,
// LFSR default seed and sequence packing helper.
package simon_game_ctrl_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADD      = 3'd1;
    localparam logic [2:0] S_SHOW_ON  = 3'd2;
    localparam logic [2:0] S_SHOW_OFF = 3'd3;
    localparam logic [2:0] S_WAIT_IN  = 3'd4;
    localparam logic [2:0] S_ECHO     = 3'd5;
    localparam logic [2:0] S_WIN      = 3'd6;
    localparam logic [2:0] S_LOSE     = 3'd7;

    typedef enum logic [1:0] {
        COLOR_RED    = 2'd0,
        COLOR_GREEN  = 2'd1,
        COLOR_BLUE   = 2'd2,
        COLOR_YELLOW = 2'd3
    } color_t;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
    localparam int          SEQ_W             = 32;

    // Entry i of the packed sequence lives at bits [2i+1:2i].
    function automatic logic [1:0] seq_entry(input logic [SEQ_W-1:0] s, input logic [3:0] i);
        return s[{i, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/simon_game_ctrl_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying the random colour stream.
module simon_lfsr
    import simon_game_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (reset)
            value <= LFSR_DEFAULT_SEED;
        else if (load)
            value <= (seed == 16'd0) ? LFSR_DEFAULT_SEED : seed;
        else if (step)
            value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
    end

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon game controller: grows a random colour sequence, plays it back on the
// LED and checks the player's presses against it.
module simon_game_ctrl
    import simon_game_ctrl_pkg::*;
#(
    parameter int ON_CYCLES      = 50_000_000,
    parameter int OFF_CYCLES     = 25_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int MAX_LEVEL      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             btn_valid,
    input  logic [1:0]       btn_color,
    input  logic [15:0]      seed,
    output logic             led_on,
    output logic [1:0]       led_color,
    output logic [SEQ_W-1:0] seq,
    output logic [4:0]       level,
    output logic             busy,
    output logic             game_won,
    output logic             game_over
);

    localparam int TMAX = (ON_CYCLES > OFF_CYCLES)
                        ? ((ON_CYCLES > TIMEOUT_CYCLES) ? ON_CYCLES : TIMEOUT_CYCLES)
                        : ((OFF_CYCLES > TIMEOUT_CYCLES) ? OFF_CYCLES : TIMEOUT_CYCLES);
    localparam int TW = $clog2(TMAX + 1);

    // Timer counts down from N-1 so a state lasts exactly N cycles.
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [4:0]    idx;
    logic [4:0]    idx_next;
    logic [15:0]   lfsr_value;
    logic          game_start;
    logic          lfsr_unused;

    assign idx_next    = idx + 5'd1;
    assign game_start  = start && (state == S_IDLE || state == S_WIN || state == S_LOSE);
    assign lfsr_unused = ^lfsr_value[15:2];

    simon_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (game_start),
        .seed  (seed),
        .step  (state == S_ADD),
        .value (lfsr_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            idx       <= '0;
            led_on    <= 1'b0;
            led_color <= 2'd0;
            seq       <= '0;
            level     <= '0;
            busy      <= 1'b0;
            game_won  <= 1'b0;
            game_over <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (game_start) begin
                        state     <= S_ADD;
                        timer     <= '0;
                        idx       <= '0;
                        seq       <= '0;
                        level     <= '0;
                        busy      <= 1'b1;
                        game_won  <= 1'b0;
                        game_over <= 1'b0;
                    end
                end
                S_ADD: begin
                    seq[{level[3:0], 1'b0} +: 2] <= lfsr_value[1:0];
                    level     <= level + 5'd1;
                    idx       <= '0;
                    state     <= S_SHOW_ON;
                    timer     <= ON_LOAD;
                    led_on    <= 1'b1;
                    // Entry 0 is being written this cycle on the first round.
                    led_color <= (level == 5'd0) ? lfsr_value[1:0] : seq[1:0];
                end
                S_SHOW_ON: begin
                    if (timer == '0) begin
                        state  <= S_SHOW_OFF;
                        timer  <= OFF_LOAD;
                        led_on <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_SHOW_OFF: begin
                    if (timer == '0) begin
                        if (idx_next < level) begin
                            idx       <= idx_next;
                            state     <= S_SHOW_ON;
                            timer     <= ON_LOAD;
                            led_on    <= 1'b1;
                            led_color <= seq_entry(seq, idx_next[3:0]);
                        end else begin
                            idx   <= '0;
                            state <= S_WAIT_IN;
                            timer <= TMO_LOAD;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_WAIT_IN: begin
                    if (btn_valid) begin
                        if (btn_color == seq_entry(seq, idx[3:0])) begin
                            state     <= S_ECHO;
                            timer     <= ON_LOAD;
                            led_on    <= 1'b1;
                            led_color <= btn_color;
                        end else begin
                            state     <= S_LOSE;
                            busy      <= 1'b0;
                            game_over <= 1'b1;
                        end
                    end else if (timer == '0) begin
                        state     <= S_LOSE;
                        busy      <= 1'b0;
                        game_over <= 1'b1;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_ECHO: begin
                    if (timer == '0) begin
                        led_on <= 1'b0;
                        idx    <= idx_next;
                        if (idx_next == level) begin
                            if (level == 5'(MAX_LEVEL)) begin
                                state    <= S_WIN;
                                busy     <= 1'b0;
                                game_won <= 1'b1;
                            end else begin
                                state <= S_ADD;
                                timer <= '0;
                            end
                        end else begin
                            state <= S_WAIT_IN;
                            timer <= TMO_LOAD;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
